// File: rtl/saturn_debug_uart_tx.sv
// saturn_debug_uart_tx: FIFO-buffered 8N1 UART transmitter for the debug character stream.
// Characters are queued from the bus controller's write strobe and shifted out LSB first.
// The line keeps draining regardless of CPU halt or clock gating.
module saturn_debug_uart_tx #(
  parameter int unsigned CLK_DIV = 104,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_char_to_send,
  input  logic               i_char_valid,
  input  logic               i_char_send,
  output logic               o_serial_busy,
  output logic               o_tx,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_overflow,
  output logic               o_tx_active
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_busy;
  logic                 r_overflow;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [7:0]           r_sh;
  logic                 r_tx;
  logic                 r_tx_active;

  logic                 w_write;
  logic                 w_drop;
  logic                 w_has_data;
  logic                 w_bit_end;
  logic                 w_pop;
  logic [7:0]           w_head;
  logic [LW-1:0]        w_level_nxt;

  // Write/drop decisions use the registered full flag; pops happen only at frame starts
  always_comb begin
    w_write     = i_char_send & i_char_valid & ~r_busy;
    w_drop      = i_char_send & i_char_valid & r_busy;
    w_has_data  = (r_level != '0);
    w_bit_end   = (r_cnt == DIV_M1);
    w_pop       = w_has_data & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    w_head      = r_mem[r_rd_ptr];
    w_level_nxt = r_level;
    case ({w_write, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage; contents are don't-care after reset since pointers and level are cleared
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_write) begin
      r_mem[r_wr_ptr] <= i_char_to_send;
    end
  end

  // Pointers, level, full flag and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_level <= w_level_nxt;
      r_busy  <= (w_level_nxt == LW'(DEPTH));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Frame FSM; o_tx is loaded with the level of the state being entered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sh        <= '0;
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx        <= 1'b1;
          r_tx_active <= 1'b0;
          if (w_pop) begin
            r_sh        <= w_head;
            r_cnt       <= '0;
            r_state     <= S_START;
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_sh[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_sh  <= {1'b0, r_sh[7:1]};
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_sh[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_sh    <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_tx        <= 1'b1;
              r_tx_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_tx        <= 1'b1;
          r_tx_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_serial_busy = r_busy;
  assign o_tx          = r_tx;
  assign o_fifo_level  = r_level;
  assign o_overflow    = r_overflow;
  assign o_tx_active   = r_tx_active;

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// tb_saturn_debug_uart_tx: directed bench with a mid-bit sampling UART receiver.
`timescale 1ns/1ps
module tb_saturn_debug_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 2;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic [7:0]       i_char_to_send = 8'h00;
  logic             i_char_valid = 1'b0;
  logic             i_char_send = 1'b0;
  logic             o_serial_busy;
  logic             o_tx;
  logic [FIFO_AW:0] o_fifo_level;
  logic             o_overflow;
  logic             o_tx_active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_q [$];
  int         st_q [$];

  saturn_debug_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_char_to_send (i_char_to_send),
    .i_char_valid   (i_char_valid),
    .i_char_send    (i_char_send),
    .o_serial_busy  (o_serial_busy),
    .o_tx           (o_tx),
    .o_fifo_level   (o_fifo_level),
    .o_overflow     (o_overflow),
    .o_tx_active    (o_tx_active)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input logic [7:0] c);
    i_char_to_send = c;
    i_char_valid   = 1'b1;
    i_char_send    = 1'b1;
    tick();
    i_char_send    = 1'b0;
    i_char_valid   = 1'b0;
  endtask

  task automatic idle_low_count(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (o_tx !== 1'b1) lows++;
      tick();
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    check_eq("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  // Receiver: start detected on first low cycle, each bit sampled 2 cycles into its period
  initial begin : rx
    logic [7:0] b;
    int sc;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_tx === 1'b0) begin
        sc = cyc;
        repeat (6) @(posedge i_clk);
        #2;
        b[0] = o_tx;
        for (int k = 1; k < 8; k++) begin
          repeat (4) @(posedge i_clk);
          #2;
          b[k] = o_tx;
        end
        repeat (4) @(posedge i_clk);
        #2;
        check_eq("rx_stop", 32'(o_tx), 32'd1);
        rx_q.push_back(b);
        st_q.push_back(sc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    logic [9:0]  frame;
    logic        samp [40];
    int          lows;
    int          n0;
    logic [7:0]  burst [5];
    logic [7:0]  wrap  [9];
    burst = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h12};
    wrap  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A};

    // Reset state
    i_reset = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_busy", 32'(o_serial_busy), 32'd0);
    check_eq("rst_level", 32'(o_fifo_level), 32'd0);
    check_eq("rst_ovf", 32'(o_overflow), 32'd0);
    check_eq("rst_active", 32'(o_tx_active), 32'd0);
    idle_low_count(100, lows);
    check_eq("rst_idle_line", 32'(lows), 32'd0);

    // Single character 0x41
    put(8'h41);
    check_eq("single_level_n", 32'(o_fifo_level), 32'd1);
    check_eq("single_tx_n", 32'(o_tx), 32'd1);
    tick();
    check_eq("single_level_n1", 32'(o_fifo_level), 32'd0);
    check_eq("single_active_n1", 32'(o_tx_active), 32'd1);
    for (int i = 0; i < 40; i++) begin
      samp[i] = o_tx;
      tick();
    end
    frame = {1'b1, 8'h41, 1'b0};
    for (int b = 0; b < 10; b++) begin
      int ok;
      ok = 1;
      for (int j = 0; j < 4; j++) if (samp[b*4+j] !== frame[b]) ok = 0;
      check_eq($sformatf("single_bit%0d_held", b), 32'(ok ? frame[b] : ~frame[b]), 32'(frame[b]));
    end
    check_eq("single_active_end", 32'(o_tx_active), 32'd0);
    check_eq("single_tx_end", 32'(o_tx), 32'd1);
    check_eq("single_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check_eq("single_rx_byte", 32'(rx_q[0]), 32'h41);
    rx_q.delete();
    st_q.delete();

    // Ignored strobe (valid low)
    i_char_to_send = 8'h77;
    i_char_valid   = 1'b0;
    i_char_send    = 1'b1;
    tick();
    i_char_send    = 1'b0;
    check_eq("ign_level", 32'(o_fifo_level), 32'd0);
    check_eq("ign_ovf", 32'(o_overflow), 32'd0);
    idle_low_count(20, lows);
    check_eq("ign_line", 32'(lows), 32'd0);
    check_eq("ign_active", 32'(o_tx_active), 32'd0);

    // Pointer wrap: 9 characters spaced 35 cycles apart
    for (int k = 0; k < 9; k++) begin
      check_eq($sformatf("wrap_busy%0d", k), 32'(o_serial_busy), 32'd0);
      put(wrap[k]);
      repeat (34) tick();
    end
    wait_rx(9, 600);
    for (int k = 0; k < 9; k++)
      if (k < rx_q.size()) check_eq($sformatf("wrap_rx%0d", k), 32'(rx_q[k]), 32'(wrap[k]));
    repeat (10) tick();
    check_eq("wrap_idle", 32'(o_tx_active), 32'd0);
    check_eq("wrap_ovf", 32'(o_overflow), 32'd0);
    rx_q.delete();
    st_q.delete();

    // Burst into full, then one write while busy
    put(burst[0]);
    n0 = cyc;
    check_eq("burst_lvl0", 32'(o_fifo_level), 32'd1);
    put(burst[1]);
    check_eq("burst_lvl1", 32'(o_fifo_level), 32'd1);
    put(burst[2]);
    check_eq("burst_lvl2", 32'(o_fifo_level), 32'd2);
    put(burst[3]);
    check_eq("burst_lvl3", 32'(o_fifo_level), 32'd3);
    check_eq("burst_busy3", 32'(o_serial_busy), 32'd0);
    put(burst[4]);
    check_eq("burst_lvl4", 32'(o_fifo_level), 32'd4);
    check_eq("burst_busy4", 32'(o_serial_busy), 32'd1);
    check_eq("burst_ovf4", 32'(o_overflow), 32'd0);
    put(8'h99);
    check_eq("burst_ovf_drop", 32'(o_overflow), 32'd1);
    check_eq("burst_lvl_drop", 32'(o_fifo_level), 32'd4);
    repeat (35) tick();
    check_eq("burst_lvl_pre_pop", 32'(o_fifo_level), 32'd4);
    check_eq("burst_busy_pre_pop", 32'(o_serial_busy), 32'd1);
    tick();
    check_eq("burst_lvl_pop2", 32'(o_fifo_level), 32'd3);
    check_eq("burst_busy_pop2", 32'(o_serial_busy), 32'd0);
    wait_rx(5, 400);
    for (int k = 0; k < 5; k++)
      if (k < rx_q.size()) check_eq($sformatf("burst_rx%0d", k), 32'(rx_q[k]), 32'(burst[k]));
    if (st_q.size() > 0) check_eq("burst_first_start", 32'(st_q[0]), 32'(n0 + 1));
    for (int k = 1; k < 5; k++)
      if (k < st_q.size()) check_eq($sformatf("burst_gap%0d", k), 32'(st_q[k] - st_q[k-1]), 32'd40);
    repeat (10) tick();
    check_eq("burst_ovf_sticky", 32'(o_overflow), 32'd1);
    check_eq("burst_idle", 32'(o_tx_active), 32'd0);
    rx_q.delete();
    st_q.delete();

    // Reset two cycles into DATA of 0x3C with two bytes queued
    put(8'h3C);
    put(8'h11);
    put(8'h22);
    repeat (5) tick();
    check_eq("mid_active", 32'(o_tx_active), 32'd1);
    check_eq("mid_level", 32'(o_fifo_level), 32'd2);
    check_eq("mid_tx_bit0", 32'(o_tx), 32'd0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("mid_rst_tx", 32'(o_tx), 32'd1);
    check_eq("mid_rst_level", 32'(o_fifo_level), 32'd0);
    check_eq("mid_rst_busy", 32'(o_serial_busy), 32'd0);
    check_eq("mid_rst_active", 32'(o_tx_active), 32'd0);
    check_eq("mid_rst_ovf", 32'(o_overflow), 32'd0);
    idle_low_count(100, lows);
    check_eq("mid_no_frames", 32'(lows), 32'd0);
    check_eq("mid_level_after", 32'(o_fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
